// File: rtl/multi_arr_result_drain_if.sv
// Handshake bundle between the array product port, the drain buffer and its word-stream consumer.
interface multi_arr_result_drain_if #(
  parameter int NUM_W = 4,
  parameter int NUM_I = 4,
  parameter int OW    = 32
);
  localparam int NUM_OUT = NUM_W * NUM_I;
  localparam int IDXW    = $clog2(NUM_OUT);

  logic [NUM_OUT*OW-1:0] ops_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [OW-1:0]         out_data;
  logic [IDXW-1:0]       out_idx;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output ops_in, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_last, out_valid
  );

  modport slave (
    input  ops_in, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_last, out_valid
  );
endinterface

// File: rtl/multi_arr_result_drain.sv
// Two-slot ping-pong capture of product vectors, drained one word per cycle in index order.
// Optional ZERO_SKIP_EN: zero words are skipped, the final index is always emitted.
module multi_arr_result_drain #(
  parameter  int NUM_W   = 4,
  parameter  int NUM_I   = 4,
  parameter  int OW      = 32,
  localparam int NUM_OUT = NUM_W * NUM_I,
  localparam int IDXW    = $clog2(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  multi_arr_result_drain_if.slave   io,
  output logic [15:0]               frames
);
  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                       state;
  logic [1:0][NUM_OUT*OW-1:0]   slot;
  logic                         wr_ptr, rd_ptr;
  logic [1:0]                   cnt, cnt_nxt;
  logic [IDXW-1:0]              wptr, cur_idx;
  logic [NUM_OUT-1:0][OW-1:0]   cur_words;
  logic                         cap, pop, last_pop;

  assign cur_words    = slot[rd_ptr];
  assign io.in_ready  = (cnt != 2'd2);
  assign io.out_valid = (state == DRAIN);
  assign cap          = io.in_valid && io.in_ready;
  assign pop          = io.out_valid && io.out_ready;
  assign last_pop     = pop && io.out_last;
  assign cnt_nxt      = cnt + {1'b0, cap} - {1'b0, last_pop};

`ifdef ZERO_SKIP_EN
  // Lowest nonzero index at or after the word pointer; the final index is the fallback.
  always_comb begin
    cur_idx = IDXW'(NUM_OUT-1);
    for (int i = NUM_OUT-2; i >= 0; i--)
      if (IDXW'(i) >= wptr && cur_words[i] != '0) cur_idx = IDXW'(i);
  end
`else
  assign cur_idx = wptr;
`endif

  assign io.out_last = io.out_valid && (cur_idx == IDXW'(NUM_OUT-1));
  assign io.out_idx  = io.out_valid ? cur_idx : '0;
  assign io.out_data = io.out_valid ? cur_words[cur_idx] : '0;

  // Slot storage needs no reset: it is only observed while out_valid is high.
  always_ff @(posedge clk)
    if (cap) slot[wr_ptr] <= io.ops_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      wptr   <= '0;
      frames <= 16'd0;
    end else begin
      cnt   <= cnt_nxt;
      state <= (cnt_nxt != 2'd0) ? DRAIN : IDLE;
      if (cap) wr_ptr <= ~wr_ptr;
      if (last_pop) begin
        wptr   <= '0;
        rd_ptr <= ~rd_ptr;
        frames <= frames + 16'd1;
      end else if (pop) begin
        wptr   <= cur_idx + IDXW'(1);
      end
    end
  end
endmodule

// File: tb/tb_multi_arr_result_drain.sv
// Randomized and directed checks of multi_arr_result_drain against a word-queue reference model.
module tb_multi_arr_result_drain;
  localparam int NUM_W   = 4;
  localparam int NUM_I   = 4;
  localparam int OW      = 32;
  localparam int NUM_OUT = NUM_W * NUM_I;
  localparam int VW      = NUM_OUT * OW;

  typedef struct {
    logic [OW-1:0] data;
    int            idx;
    logic          last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frames;

  multi_arr_result_drain_if #(.NUM_W(NUM_W), .NUM_I(NUM_I), .OW(OW)) bus();

  multi_arr_result_drain #(.NUM_W(NUM_W), .NUM_I(NUM_I), .OW(OW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io     (bus),
    .frames (frames)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_fail = 0;
  word_t         exp_q[$];
  int            mcnt = 0;
  logic [15:0]   mframes = 16'd0;
  int            pop_idx[$];
  logic [OW-1:0] pop_data[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // A captured vector becomes the list of words the consumer should see.
  task automatic push_vec(input logic [VW-1:0] v);
    logic [OW-1:0] w;
    for (int k = 0; k < NUM_OUT; k++) begin
      w = v[k*OW +: OW];
`ifdef ZERO_SKIP_EN
      if (w == '0 && k != NUM_OUT-1) continue;
`endif
      exp_q.push_back('{data: w, idx: k, last: (k == NUM_OUT-1)});
    end
  endtask

  function automatic logic [VW-1:0] rand_vec(input int zero_pct);
    logic [VW-1:0] v;
    for (int k = 0; k < NUM_OUT; k++)
      v[k*OW +: OW] = ($urandom_range(0, 99) < zero_pct) ? '0 : OW'($urandom);
    return v;
  endfunction

  // One clock: drive, check at negedge, advance the model, return 1 ns past the edge.
  task automatic cycle(input logic iv, input logic [VW-1:0] ops, input logic ordy, output logic acc);
    word_t w;
    bus.in_valid  = iv;
    bus.ops_in    = ops;
    bus.out_ready = ordy;
    @(negedge clk);
    chk("in_ready", bus.in_ready, mcnt != 2);
    chk("out_valid", bus.out_valid, exp_q.size() != 0);
    chk("frames", frames, mframes);
    acc = iv && (mcnt != 2);
    if (exp_q.size() != 0) begin
      chk("out_data", bus.out_data, exp_q[0].data);
      chk("out_idx", bus.out_idx, exp_q[0].idx);
      chk("out_last", bus.out_last, exp_q[0].last);
      if (ordy) begin
        pop_idx.push_back(int'(bus.out_idx));
        pop_data.push_back(bus.out_data);
        w = exp_q.pop_front();
        if (w.last) begin
          mcnt--;
          mframes++;
        end
      end
    end
    if (acc) begin
      push_vec(ops);
      mcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int ncyc);
    logic a;
    ncyc = 0;
    while (exp_q.size() != 0 && ncyc < 400) begin
      cycle(1'b0, '0, 1'b1, a);
      ncyc++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [VW-1:0] va, vb, vc, pend;
    logic [OW-1:0] wts[4], ips[4];
    logic          acc, have;
    int            n;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.ops_in = '0; bus.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_frames", frames, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single known vector
    wts = '{32'h34, 32'h24, 32'h35, 32'h36};
    ips = '{32'd1, 32'd4, 32'd3, 32'd5};
    for (int k = 0; k < NUM_OUT; k++) va[k*OW +: OW] = wts[k/NUM_I] * ips[k%NUM_I];
    pop_idx.delete(); pop_data.delete();
    cycle(1'b1, va, 1'b1, acc);
    drain(n);
    chk("t1_cycles", n, 16);
    chk("t1_words", pop_data.size(), 16);
    if (pop_data.size() == 16) begin
      chk("t1_idx0", pop_data[0], 32'h34);
      chk("t1_idx1", pop_data[1], 32'hD0);
      chk("t1_idx5", pop_data[5], 32'h90);
      chk("t1_idx15", pop_data[15], 32'h10E);
    end
    chk("t1_frames", frames, 1);

    // Ping-pong with the consumer stalled, then released
    va = rand_vec(10); vb = rand_vec(10); vc = rand_vec(10);
    cycle(1'b1, va, 1'b0, acc);
    cycle(1'b1, vb, 1'b0, acc);
    for (int c = 0; c < 3; c++) cycle(1'b1, vc, 1'b0, acc);
    acc = 1'b0;
    for (int c = 0; c < 100 && !acc; c++) cycle(1'b1, vc, 1'b1, acc);
    chk("t2_c_taken", acc, 1);
    drain(n);
    chk("t2_frames", frames, 4);

    // Alternating backpressure on a vector with no zero words
    cycle(1'b1, rand_vec(0), 1'b0, acc);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycle(1'b0, '0, n[0], acc);
      n++;
    end
    chk("t3_cycles", n, 32);

    // Capture lands on the same edge as the last-word pop
    cycle(1'b1, rand_vec(0), 1'b1, acc);
    for (int c = 0; c < 100 && exp_q.size() > 1; c++) cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b1, rand_vec(0), 1'b1, acc);
    cycle(1'b0, '0, 1'b0, acc);
    drain(n);

    // Reset while two vectors are buffered
    cycle(1'b1, rand_vec(0), 1'b0, acc);
    cycle(1'b1, rand_vec(0), 1'b0, acc);
    for (int c = 0; c < 50 && exp_q[0].idx != 7; c++) cycle(1'b0, '0, 1'b1, acc);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_frames", frames, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    exp_q.delete(); mcnt = 0; mframes = 16'd0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b1, rand_vec(20), 1'b1, acc);
    drain(n);

`ifdef ZERO_SKIP_EN
    va = '0; va[3*OW +: OW] = 32'd5;
    pop_idx.delete(); pop_data.delete();
    cycle(1'b1, va, 1'b1, acc);
    drain(n);
    chk("t6_words", pop_idx.size(), 2);
    if (pop_idx.size() == 2) begin
      chk("t6_idx_a", pop_idx[0], 3);
      chk("t6_data_a", pop_data[0], 5);
      chk("t6_idx_b", pop_idx[1], 15);
      chk("t6_data_b", pop_data[1], 0);
    end
    pop_idx.delete(); pop_data.delete();
    cycle(1'b1, '0, 1'b1, acc);
    drain(n);
    chk("t6z_words", pop_idx.size(), 1);
    if (pop_idx.size() == 1) chk("t6z_idx", pop_idx[0], 15);
`endif

    // Random traffic on both sides
    have = 1'b0;
    pend = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!have) begin
        pend = rand_vec(30);
        have = 1'b1;
      end
      cycle($urandom_range(0, 2) != 0, pend, $urandom_range(0, 3) != 0, acc);
      if (acc) have = 1'b0;
    end
    drain(n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
